uart_rx: RTL and testbench

UART receiver for the serial link whose transmitter runs one bit per transmit clock. The frame is a start bit (0), WIDTH data bits LSB first, an optional even-parity bit, and a stop bit (1). The block oversamples the asynchronous `rx` line on its own clock, samples each bit at mid-bit, and presents each received word with a one-cycle valid strobe and per-frame error flags. It sits at the serial input of the design, facing the link.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, default sizing
// and the idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus a 1->0 edge
// detector on the synchronized level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // All flops reset to the idle level so reset release never looks like an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= LINE_IDLE;
            sync_q <= LINE_IDLE;
            prev_q <= LINE_IDLE;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_o   = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, mid-bit sampling, one-cycle valid strobe.
// Define UART_RX_PARITY_EN to include the even-parity bit in the frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic             rx_clk,
    input  logic             rx_reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data_out,
    output logic             rx_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] HALF  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = S_PARITY;
`else
    localparam state_e AFTER_DATA = S_STOP;
`endif

    logic rx_s;
    logic fall;

    uart_rx_sync u_sync (
        .clk_i  (rx_clk),
        .rst_ni (rx_reset),
        .rx_i   (rx),
        .rx_o   (rx_s),
        .fall_o (fall)
    );

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic             perr_q, perr_d;
    logic             perr_out_q, perr_out_d;
`endif

    always_ff @(posedge rx_clk or negedge rx_reset) begin
        if (!rx_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
            perr_out_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q     <= perr_d;
            perr_out_q <= perr_out_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
        perr_d     = perr_q;
        perr_out_d = perr_out_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A line back high at mid-start is a glitch, not a frame
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[WIDTH-1:1]};
                    if (bit_q == BLAST) begin
                        state_d = AFTER_DATA;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ (^shift_q);
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge
                if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    dout_d     = shift_q;
                    valid_d    = 1'b1;
                    ferr_d     = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_out_d = perr_q;
`endif
                    state_d    = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign data_out  = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_out_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx (WIDTH=8, OVERSAMPLE=16).
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int OS    = 16;
    localparam int LAT   = 2 + OS / 2 + OS * (NBITS - 1) + 1;
    localparam int FRAME = OS * NBITS;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(
        .WIDTH      (8),
        .OVERSAMPLE (OS)
    ) dut (
        .rx_clk     (clk),
        .rx_reset   (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vcount = 0;
    int         vcyc   = 0;
    int         pcyc   = 0;
    logic [7:0] vdata  = 8'h00;
    logic [7:0] pdata  = 8'h00;
    logic       vperr  = 1'b0;
    logic       vferr  = 1'b0;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            vcount = vcount + 1;
            pcyc   = vcyc;
            pdata  = vdata;
            vcyc   = cyc;
            vdata  = data_out;
            vperr  = parity_err;
            vferr  = frame_err;
        end
    end

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal = ntotal + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    int t0 = 0;

    task automatic hold_bit(input logic b);
        rx = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic stp);
        t0 = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
        if (PAR) hold_bit(p);
        hold_bit(stp);
        rx = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(data_out), 32'h0);
        chk({tag, "_valid"}, 32'(rx_valid), 32'h0);
        chk({tag, "_perr"}, 32'(parity_err), 32'h0);
        chk({tag, "_ferr"}, 32'(frame_err), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    int vc0;
    int ta;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5, correct parity
        vc0 = vcount;
        send(8'hA5, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("a5_count", 32'(vcount), 32'(vc0 + 1));
        chk("a5_latency", 32'(vcyc), 32'(t0 + LAT));
        chk("a5_data", 32'(vdata), 32'hA5);
        chk("a5_perr", 32'(vperr), 32'h0);
        chk("a5_ferr", 32'(vferr), 32'h0);
        chk("a5_hold", 32'(data_out), 32'hA5);

        // 0x01 with wrong parity bit
        vc0 = vcount;
        send(8'h01, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("01_count", 32'(vcount), 32'(vc0 + 1));
        chk("01_data", 32'(vdata), 32'h01);
        chk("01_perr", 32'(vperr), 32'(PAR));
        chk("01_ferr", 32'(vferr), 32'h0);

        // 0x3C with bad stop bit, then idle high
        vc0 = vcount;
        send(8'h3C, 1'b0, 1'b0);
        repeat (200) @(negedge clk);
        chk("3c_count", 32'(vcount), 32'(vc0 + 1));
        chk("3c_data", 32'(vdata), 32'h3C);
        chk("3c_ferr", 32'(vferr), 32'h1);
        chk("3c_perr", 32'(vperr), 32'h0);
        chk("3c_busy", 32'(busy), 32'h0);

        // 5-cycle glitch
        vc0 = vcount;
        t0  = cyc;
        rx  = 1'b0;
        repeat (5) @(negedge clk);
        rx  = 1'b1;
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (6) @(negedge clk);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        repeat (40) @(negedge clk);
        chk("glitch_nostrobe", 32'(vcount), 32'(vc0));
        send(8'h5A, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("5a_count", 32'(vcount), 32'(vc0 + 1));
        chk("5a_latency", 32'(vcyc), 32'(t0 + LAT));
        chk("5a_data", 32'(vdata), 32'h5A);
        chk("5a_perr", 32'(vperr), 32'h0);
        chk("5a_ferr", 32'(vferr), 32'h0);

        // back-to-back 0x00, 0xFF
        vc0 = vcount;
        send(8'h00, 1'b0, 1'b1);
        ta = t0;
        send(8'hFF, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("b2b_count", 32'(vcount), 32'(vc0 + 2));
        chk("b2b_first_lat", 32'(pcyc), 32'(ta + LAT));
        chk("b2b_gap", 32'(vcyc - pcyc), 32'(FRAME));
        chk("b2b_first_data", 32'(pdata), 32'h00);
        chk("b2b_data", 32'(vdata), 32'hFF);
        chk("b2b_perr", 32'(vperr), 32'h0);
        chk("b2b_ferr", 32'(vferr), 32'h0);

        // reset in the middle of the data bits
        vc0 = vcount;
        hold_bit(1'b0);
        hold_bit(1'b1);
        hold_bit(1'b0);
        hold_bit(1'b1);
        repeat (OS / 2) @(negedge clk);
        chk("midrst_busy_pre", 32'(busy), 32'h1);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("midrst_nostrobe", 32'(vcount), 32'(vc0));
        chk("midrst_idle", 32'(busy), 32'h0);
        send(8'h81, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("81_count", 32'(vcount), 32'(vc0 + 1));
        chk("81_latency", 32'(vcyc), 32'(t0 + LAT));
        chk("81_data", 32'(vdata), 32'h81);
        chk("81_perr", 32'(vperr), 32'h0);
        chk("81_ferr", 32'(vferr), 32'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
